onehot_mux: RTL and testbench

ONEHOT_MUX -- requirements
Module: onehot_mux

---
 rtl/onehot_mux_pkg.sv | 17 +
 rtl/onehot_check.sv | 30 +++
 rtl/onehot_mux.sv | 80 ++++++++
 tb/tb_onehot_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/onehot_mux_pkg.sv
// ============================================================================
// onehot_mux_pkg : shared system data typedef and select-width limits
// Rev 1.0
// ============================================================================
`default_nettype none

package onehot_mux_pkg;

    typedef logic [31:0] DATA;

    localparam int unsigned DATA_W    = $bits(DATA);
    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;

endpackage : onehot_mux_pkg

`default_nettype wire

// File: rtl/onehot_check.sv
// ============================================================================
// onehot_check : classifies a select vector as zero, one-hot or multi-hot
// Rev 1.0
// ============================================================================
`default_nettype none

module onehot_check
    import onehot_mux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic             zero,
    output logic             one_hot,
    output logic             multi_hot
);

    logic [WIDTH-1:0] low_cleared;

    // Clearing the lowest set bit leaves zero only when at most one bit was set.
    always_comb begin
        low_cleared = vec & (vec - WIDTH'(1));
        zero        = ~|vec;
        one_hot     = ~zero & ~|low_cleared;
        multi_hot   = |low_cleared;
    end

endmodule : onehot_check

`default_nettype wire

// File: rtl/onehot_mux.sv
// ============================================================================
// onehot_mux : AND-OR one-hot multiplexer with optional sticky select checker
// Optional checker enabled by macro ONEHOT_MUX_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module onehot_mux
    import onehot_mux_pkg::*;
#(
    parameter int SIZE  = DATA_W,
    parameter int WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0][SIZE-1:0] in,
    input  logic [WIDTH-1:0]           select,
    output logic [SIZE-1:0]            out,
    output logic                       any_sel,
    output logic                       sel_err
);

    logic [WIDTH-1:0][SIZE-1:0] terms;

    for (genvar i = 0; i < WIDTH; i++) begin : g_term
        assign terms[i] = in[i] & {SIZE{select[i]}};
    end

    // Flat OR of masked candidates: multi-hot selects merge, nothing has priority.
    always_comb begin
        out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out = out | terms[i];
        end
    end

    assign any_sel = |select;

`ifdef ONEHOT_MUX_CHECK_EN
    logic sel_zero;
    logic sel_one_hot;
    logic sel_multi_hot;
    logic sel_err_q;
    logic unused_class;

    onehot_check #(
        .WIDTH     (WIDTH)
    ) u_onehot_check (
        .vec       (select),
        .zero      (sel_zero),
        .one_hot   (sel_one_hot),
        .multi_hot (sel_multi_hot)
    );

    assign unused_class = sel_zero ^ sel_one_hot;

    always_ff @(posedge clock) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else if (sel_multi_hot) begin
            sel_err_q <= 1'b1;
`ifndef SYNTHESIS
            if (!sel_err_q) begin
                $error("onehot_mux: non-one-hot select 0x%0h", select);
            end
`endif
        end
    end

    assign sel_err = sel_err_q;
`else
    logic unused_clk_rst;

    // Checker compiled out: clock and reset have no loads in this build.
    assign unused_clk_rst = clock ^ reset;
    assign sel_err        = 1'b0;
`endif

endmodule : onehot_mux

`default_nettype wire

// File: tb/tb_onehot_mux.sv
// ============================================================================
// tb_onehot_mux : directed checks plus per-cycle model comparison of onehot_mux
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_onehot_mux;

`ifdef ONEHOT_MUX_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [3:0][31:0] in4;
    logic [3:0]       sel4;
    logic [31:0]      out4;
    logic             any4;
    logic             err4;
    logic [0:0][7:0]  in1;
    logic [0:0]       sel1;
    logic [7:0]       out1;
    logic             any1;
    logic             err1;

    int checks   = 0;
    int failures = 0;

    logic m_err   = 1'b0;
    bit   m_valid = 1'b0;

    always #5 clock = ~clock;

    onehot_mux #(.SIZE(32), .WIDTH(4)) dut4 (
        .clock(clock), .reset(reset), .in(in4), .select(sel4),
        .out(out4), .any_sel(any4), .sel_err(err4)
    );

    onehot_mux #(.SIZE(8), .WIDTH(1)) dut1 (
        .clock(clock), .reset(reset), .in(in1), .select(sel1),
        .out(out1), .any_sel(any1), .sel_err(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h", name, act, exp);
        end
    endtask

    // Expected output: OR together every candidate whose index appears in the select.
    function automatic logic [31:0] model_out(input logic [3:0][31:0] d, input logic [3:0] s);
        int          chosen[$];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (s[i]) chosen.push_back(i);
        foreach (chosen[k]) r = r | d[chosen[k]];
        return r;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else if (CHECK_EN && $countones(sel4) > 1) begin
            m_err = 1'b1;
        end
        #1;
        check("mon_out4", out4, model_out(in4, sel4));
        check("mon_any4", {31'd0, any4}, {31'd0, (sel4 != 4'd0)});
        check("mon_out1", {24'd0, out1}, {24'd0, (sel1[0] ? in1[0] : 8'h00)});
        check("mon_any1", {31'd0, any1}, {31'd0, sel1[0]});
        if (m_valid) begin
            check("mon_err4", {31'd0, err4}, {31'd0, m_err});
            check("mon_err1", {31'd0, err1}, 32'd0);
        end
    end

    initial begin
        logic [3:0][31:0] pin_vec;
        logic [3:0]       steps [4];
        logic [31:0]      step_exp [4];
        int               r;

        reset = 1'b1;
        in4   = '0;
        sel4  = 4'd0;
        in1   = '0;
        sel1  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_err4", {31'd0, err4}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Model pin: two disjoint nibbles merged by a multi-hot select.
        pin_vec    = '0;
        pin_vec[0] = 32'h0000F000;
        pin_vec[2] = 32'h000000F0;
        check("model_pin_multi", model_out(pin_vec, 4'b0101), 32'h0000F0F0);
        check("model_pin_zero", model_out(pin_vec, 4'b0000), 32'h00000000);

        in4  = {32'hB1F05663, 32'h8484D609, 32'hC0895E81, 32'h12153524};
        sel4 = 4'b0000;
        #2;
        check("sel_zero_out", out4, 32'h00000000);
        check("sel_zero_any", {31'd0, any4}, 32'd0);

        steps    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        step_exp = '{32'h12153524, 32'hC0895E81, 32'h8484D609, 32'hB1F05663};
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            sel4 = steps[k];
            #2;
            check($sformatf("onehot_step%0d_out", k), out4, step_exp[k]);
            check($sformatf("onehot_step%0d_any", k), {31'd0, any4}, 32'd1);
        end

        @(negedge clock);
        in4    = '0;
        in4[0] = 32'h0000F000;
        in4[2] = 32'h000000F0;
        sel4   = 4'b0101;
        #2;
        check("multi_or_out", out4, 32'h0000F0F0);

        // Sticky behaviour: one multi-hot edge, then a legal select.
        @(negedge clock);
        reset = 1'b1;
        sel4  = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        sel4  = 4'b0011;
        @(negedge clock);
        sel4 = 4'b0001;
        check("sticky_set", {31'd0, err4}, {31'd0, CHECK_EN});
        repeat (2) @(negedge clock);
        check("sticky_hold", {31'd0, err4}, {31'd0, CHECK_EN});
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("sticky_clear", {31'd0, err4}, 32'd0);

        // Reset wins over a simultaneous multi-hot select.
        reset = 1'b1;
        sel4  = 4'b1111;
        @(negedge clock);
        check("reset_priority", {31'd0, err4}, 32'd0);
        reset = 1'b0;

        // Multi-hot held for three edges.
        in4 = {32'h80000000, 32'h00040000, 32'h00000200, 32'h00000001};
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("hold1111_out%0d", k), out4, 32'h80040201);
            if (!CHECK_EN) check($sformatf("hold1111_err%0d", k), {31'd0, err4}, 32'd0);
        end
        reset = 1'b1;
        sel4  = 4'b0000;
        @(negedge clock);
        reset = 1'b0;

        // Single-input instance.
        in1[0] = 8'hA5;
        sel1   = 1'b1;
        #2;
        check("w1_sel1_out", {24'd0, out1}, 32'h000000A5);
        @(negedge clock);
        sel1 = 1'b0;
        #2;
        check("w1_sel0_out", {24'd0, out1}, 32'h00000000);

        // Random data with legal selects, left to the per-cycle model.
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) in4[i] = $urandom;
            r      = $urandom_range(0, 4);
            sel4   = (r == 4) ? 4'b0000 : 4'(1 << r);
            in1[0] = 8'($urandom);
            sel1   = 1'($urandom_range(0, 1));
        end

        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_onehot_mux

`default_nettype wire
